// File: rtl/dtack_wait_gen.sv
// 68k DTACK wait-state generator: prioritised zone decode, per-zone wait counts,
// optional external-ready handshake and a bus-error timeout on stalled handshakes.
module dtack_wait_gen #(
  parameter int NZONES  = 6,
  parameter int CNT_W   = 4,
  parameter int TMO_W   = 6,
  parameter int TIMEOUT = 48
) (
  input  logic                    CLK_68KCLK,
  input  logic                    nRESET,
  input  logic                    nAS,
  input  logic [NZONES-1:0]       nZONE,
  input  logic [NZONES*CNT_W-1:0] WAIT_CFG,
  input  logic [NZONES-1:0]       EXT_EN,
  input  logic                    EXT_READY,
  output logic                    nDTACK,
  output logic                    nBERR,
  output logic [2:0]              ZONE_IDX,
  output logic                    BUSY
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNT    = 3'd1,
    EXT_WAIT = 3'd2,
    ACK      = 3'd3,
    BERR     = 3'd4
  } state_t;

  // Index reported when no zone select is active (unmapped access).
  localparam logic [2:0]       NO_ZONE  = 3'(NZONES);
  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [TMO_W-1:0]   tmo_r, tmo_s;
  logic               ext_r, ext_s;
  logic [2:0]         zone_r, zone_s;
  logic               ndtack_r, ndtack_s;
  logic               nberr_r, nberr_s;
  logic               busy_r, busy_s;

  logic [NZONES-1:0]  zone_low_s;
  logic [NZONES-1:0]  grant_s;
  logic [2:0]         sel_zone_s;
  logic [CNT_W-1:0]   sel_cnt_s;
  logic               sel_ext_s;
  logic               tmo_hit_s;

  // Zone decode: isolate the lowest active select and mux its configuration.
  always_comb begin
    zone_low_s = ~nZONE;
    grant_s    = zone_low_s & (~zone_low_s + NZONES'(1));
    sel_zone_s = (grant_s == '0) ? NO_ZONE : 3'd0;
    sel_cnt_s  = '0;
    sel_ext_s  = 1'b0;
    for (int i = 0; i < NZONES; i++) begin
      sel_zone_s = sel_zone_s | (grant_s[i] ? 3'(i) : 3'd0);
      sel_cnt_s  = sel_cnt_s | ({CNT_W{grant_s[i]}} & WAIT_CFG[i*CNT_W +: CNT_W]);
      sel_ext_s  = sel_ext_s | (grant_s[i] & EXT_EN[i]);
    end
  end

  assign tmo_hit_s = TMO_EN && (tmo_r == TMO_LAST);

  // Next-state logic; nAS high always returns to IDLE ahead of any other event.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tmo_s   = tmo_r;
    ext_s   = ext_r;
    zone_s  = zone_r;
    case (state_r)
      IDLE: begin
        if (!nAS) begin
          zone_s  = sel_zone_s;
          cnt_s   = sel_cnt_s;
          ext_s   = sel_ext_s;
          tmo_s   = '0;
          state_s = COUNT;
        end else begin
          state_s = IDLE;
        end
      end
      COUNT: begin
        if (nAS) begin
          state_s = IDLE;
        end else if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (ext_r) begin
          tmo_s   = '0;
          state_s = EXT_WAIT;
        end else begin
          state_s = ACK;
        end
      end
      EXT_WAIT: begin
        if (nAS) begin
          state_s = IDLE;
        end else if (EXT_READY) begin
          state_s = ACK;
        end else if (tmo_hit_s) begin
          state_s = BERR;
        end else if (tmo_r != TMO_MAX) begin
          tmo_s = tmo_r + TMO_W'(1);
        end else begin
          tmo_s = tmo_r;
        end
      end
      ACK, BERR: begin
        if (nAS) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the pins are registered with the state.
  always_comb begin
    ndtack_s = (state_s != ACK);
    nberr_s  = (state_s != BERR);
    busy_s   = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      tmo_r    <= '0;
      ext_r    <= 1'b0;
      zone_r   <= NO_ZONE;
      ndtack_r <= 1'b1;
      nberr_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      tmo_r    <= tmo_s;
      ext_r    <= ext_s;
      zone_r   <= zone_s;
      ndtack_r <= ndtack_s;
      nberr_r  <= nberr_s;
      busy_r   <= busy_s;
    end
  end

  assign nDTACK   = ndtack_r;
  assign nBERR    = nberr_r;
  assign ZONE_IDX = zone_r;
  assign BUSY     = busy_r;

endmodule

// File: tb/tb_dtack_wait_gen.sv
// Self-checking bench for dtack_wait_gen: expected acknowledge events are queued
// when a bus cycle starts and matched when nDTACK/nBERR falls.
module tb_dtack_wait_gen;

  localparam int NZONES  = 6;
  localparam int CNT_W   = 4;
  localparam int TMO_W   = 6;
  localparam int TIMEOUT = 48;

  logic                    clk = 1'b0;
  logic                    n_reset;
  logic                    n_as;
  logic [NZONES-1:0]       n_zone;
  logic [NZONES*CNT_W-1:0] wait_cfg;
  logic [NZONES-1:0]       ext_en;
  logic                    ext_ready;
  logic                    n_dtack;
  logic                    n_berr;
  logic [2:0]              zone_idx;
  logic                    busy;

  typedef struct {
    int         kind;     // 0 = DTACK, 1 = BERR
    int         edge_no;
    logic [2:0] zone;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  logic prev_dtack = 1'b1;
  logic prev_berr  = 1'b1;
  logic both_low   = 1'b0;

  dtack_wait_gen #(
    .NZONES(NZONES), .CNT_W(CNT_W), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_68KCLK(clk),
    .nRESET    (n_reset),
    .nAS       (n_as),
    .nZONE     (n_zone),
    .WAIT_CFG  (wait_cfg),
    .EXT_EN    (ext_en),
    .EXT_READY (ext_ready),
    .nDTACK    (n_dtack),
    .nBERR     (n_berr),
    .ZONE_IDX  (zone_idx),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every falling acknowledge must match the oldest queued event.
  always @(negedge clk) begin
    exp_t e;
    if (!n_dtack && !n_berr) both_low <= 1'b1;
    if ((prev_dtack && !n_dtack) || (prev_berr && !n_berr)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", n_dtack ? 1 : 0, e.kind);
        chk("sb_edge", edge_cnt, e.edge_no);
        chk("sb_zone", zone_idx, e.zone);
      end
    end
    prev_dtack <= n_dtack;
    prev_berr  <= n_berr;
  end

  // One complete bus cycle; ready_at = edge offset from E0 where EXT_READY is first sampled high.
  task automatic bus_cycle(input string tag, input logic [5:0] nz, input logic [5:0] ext,
                           input int lat, input int kind, input int zone, input int ready_at);
    exp_t e;
    int   e0;
    bit   done;
    @(negedge clk);
    n_zone    = nz;
    ext_en    = ext;
    n_as      = 1'b0;
    ext_ready = (ready_at == 0);
    e0        = edge_cnt + 1;
    e.kind    = kind;
    e.edge_no = e0 + lat;
    e.zone    = 3'(zone);
    sb.push_back(e);
    done = 1'b0;
    for (int k = 0; k < lat + 4 && !done; k++) begin
      @(negedge clk);
      if (!n_dtack || !n_berr) done = 1'b1;
      else if (ready_at > 0 && edge_cnt + 1 >= e0 + ready_at) ext_ready = 1'b1;
    end
    if (!done) begin
      chk({tag, "_resp"}, 0, 1);
    end else begin
      repeat (2) @(negedge clk);
      chk({tag, "_hold"}, (kind == 0) ? n_dtack : n_berr, 0);
    end
    n_as      = 1'b1;
    ext_ready = 1'b0;
    n_zone    = '1;
    @(negedge clk);
    chk({tag, "_rel_dtack"}, n_dtack, 1);
    chk({tag, "_rel_berr"}, n_berr, 1);
    chk({tag, "_rel_busy"}, busy, 0);
    chk({tag, "_zone"}, zone_idx, zone);
  endtask

  initial begin
    exp_t e;
    int   e0;
    // zone5=15 zone4=0 zone3=1 zone2=5 zone1=2 zone0=3
    wait_cfg  = {4'd15, 4'd0, 4'd1, 4'd5, 4'd2, 4'd3};
    ext_en    = '0;
    ext_ready = 1'b0;
    n_zone    = '1;
    n_as      = 1'b1;
    n_reset   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dtack", n_dtack, 1);
    chk("rst_berr", n_berr, 1);
    chk("rst_zone", zone_idx, 6);
    chk("rst_busy", busy, 0);
    n_reset = 1'b1;

    bus_cycle("t1_zone2", 6'b111011, 6'b000000, 6, 0, 2, -1);
    bus_cycle("t2_unmapped", 6'b111111, 6'b000000, 1, 0, 6, -1);
    bus_cycle("t3_ext_late", 6'b111101, 6'b000010, 7, 0, 1, 7);
    bus_cycle("t3_ext_early", 6'b111101, 6'b000010, 4, 0, 1, 0);
    bus_cycle("t3_noext", 6'b111101, 6'b000000, 3, 0, 1, -1);
    bus_cycle("t4_timeout", 6'b110111, 6'b001000, 50, 1, 3, -1);
    bus_cycle("t4_ready_on_tmo", 6'b110111, 6'b001000, 50, 0, 3, 50);
    bus_cycle("max_wait", 6'b011111, 6'b000000, 16, 0, 5, -1);
    bus_cycle("prio_mix", 6'b010011, 6'b000000, 6, 0, 2, -1);

    // Abort: nAS rises on the count-expiry edge of zone 0 (N=3, expiry at E0+4).
    @(negedge clk);
    n_zone = 6'b111100;
    n_as   = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_busy_before", busy, 1);
    n_as = 1'b1;
    @(negedge clk);
    chk("t5_no_dtack", n_dtack, 1);
    chk("t5_busy", busy, 0);
    chk("t5_zone", zone_idx, 0);
    n_zone = '1;
    @(negedge clk);
    chk("t5_still_idle", n_dtack, 1);

    // Reset while counting.
    @(negedge clk);
    n_zone = 6'b111011;
    n_as   = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_cnt_busy", busy, 1);
    n_reset = 1'b0;
    #1;
    chk("t6_cnt_dtack", n_dtack, 1);
    chk("t6_cnt_busy0", busy, 0);
    chk("t6_cnt_zone", zone_idx, 6);
    n_as   = 1'b1;
    n_zone = '1;
    @(negedge clk);
    n_reset = 1'b1;
    bus_cycle("t6_after_cnt", 6'b111011, 6'b000000, 6, 0, 2, -1);

    // Reset while acknowledging (zone 4, N=0).
    @(negedge clk);
    n_zone    = 6'b101111;
    n_as      = 1'b0;
    e0        = edge_cnt + 1;
    e.kind    = 0;
    e.edge_no = e0 + 1;
    e.zone    = 3'd4;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    chk("t6_ack_low", n_dtack, 0);
    n_reset = 1'b0;
    #1;
    chk("t6_ack_dtack", n_dtack, 1);
    chk("t6_ack_busy", busy, 0);
    n_as   = 1'b1;
    n_zone = '1;
    @(negedge clk);
    n_reset = 1'b1;
    bus_cycle("t6_after_ack", 6'b111111, 6'b000000, 1, 0, 6, -1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("never_both_low", both_low, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
